// File: rtl/huff_sort_pkg.sv
// rtl/huff_sort_pkg.sv - shared types and constants for the Huffman frequency sorter
//
// Contents:
//   FREQ_W_DEF / SYM_W_DEF : default key and symbol widths
//   slot_t                 : one sort slot {occ, freq, sym} at default widths
//   EMPTY_SLOT             : unoccupied slot, key and symbol all-ones
//   state_t                : sorter phase, LOAD (accept pairs) or DRAIN (emit pairs)
package huff_sort_pkg;

    localparam int FREQ_W_DEF = 8;
    localparam int SYM_W_DEF  = 8;

    typedef struct packed {
        logic                  occ;
        logic [FREQ_W_DEF-1:0] freq;
        logic [SYM_W_DEF-1:0]  sym;
    } slot_t;

    localparam slot_t EMPTY_SLOT = '{occ: 1'b0, freq: '1, sym: '1};

    typedef enum logic [0:0] {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/huff_sort_slot.sv
// rtl/huff_sort_slot.sv - one register slot of the parallel shift-insert sorter
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   clr             : synchronous clear to the empty slot
//   ins             : a new pair is being inserted this cycle
//   pop             : the head is leaving; every slot takes its upper neighbour
//   new_freq/new_sym: pair being inserted
//   prev_gt         : lower neighbour's key exceeds the new key (0 for slot 0)
//   prev_*          : lower neighbour contents (slot i-1)
//   next_*          : upper neighbour contents (slot i+1, empty for the top slot)
//   occ/freq/sym    : this slot's contents
//   gt              : this slot sorts after the new pair (empty or larger key)
//
// Macro SORT_NEW_FIRST_TIE_EN: when defined, equal keys also count as "after",
// so a new pair lands in front of existing pairs with the same key.
module huff_sort_slot #(
    parameter int FREQ_W = 8,
    parameter int SYM_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              ins,
    input  logic              pop,
    input  logic [FREQ_W-1:0] new_freq,
    input  logic [SYM_W-1:0]  new_sym,
    input  logic              prev_gt,
    input  logic              prev_occ,
    input  logic [FREQ_W-1:0] prev_freq,
    input  logic [SYM_W-1:0]  prev_sym,
    input  logic              next_occ,
    input  logic [FREQ_W-1:0] next_freq,
    input  logic [SYM_W-1:0]  next_sym,
    output logic              occ,
    output logic [FREQ_W-1:0] freq,
    output logic [SYM_W-1:0]  sym,
    output logic              gt
);

    // Occupancy dominates the key so an all-ones input still beats empty slots.
`ifdef SORT_NEW_FIRST_TIE_EN
    assign gt = !occ || (freq >= new_freq);
`else
    assign gt = !occ || (freq > new_freq);
`endif

    // Sorted order makes gt monotonic across slots, so the first slot with gt set
    // is the one whose lower neighbour has it clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ  <= 1'b0;
            freq <= '1;
            sym  <= '1;
        end else if (clr) begin
            occ  <= 1'b0;
            freq <= '1;
            sym  <= '1;
        end else if (pop) begin
            occ  <= next_occ;
            freq <= next_freq;
            sym  <= next_sym;
        end else if (ins) begin
            if (prev_gt) begin
                occ  <= prev_occ;
                freq <= prev_freq;
                sym  <= prev_sym;
            end else if (gt) begin
                occ  <= 1'b1;
                freq <= new_freq;
                sym  <= new_sym;
            end
        end
    end

endmodule

// File: rtl/huff_freq_sorter.sv
// rtl/huff_freq_sorter.sv - insertion sorter feeding the Huffman tree builder
//
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   clr                              : synchronous clear, empties slots, back to LOAD
//   in_valid/in_ready                : input handshake (LOAD only)
//   in_freq/in_sym/in_last           : pair to insert, in_last closes the batch
//   out_valid/out_ready              : output handshake (DRAIN only)
//   out_freq/out_sym/out_last        : lowest pair, out_last marks the final one
//   count                            : number of occupied slots
//
// Macro SORT_NEW_FIRST_TIE_EN: when defined, ties drain newest-first instead of
// in arrival order.
module huff_freq_sorter
    import huff_sort_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int FREQ_W = FREQ_W_DEF,
    parameter int SYM_W  = SYM_W_DEF,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FREQ_W-1:0] in_freq,
    input  logic [SYM_W-1:0]  in_sym,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FREQ_W-1:0] out_freq,
    output logic [SYM_W-1:0]  out_sym,
    output logic              out_last,
    output logic [CNT_W-1:0]  count
);

    localparam logic [0:0]       ST_LOAD  = 1'b0;
    localparam logic [0:0]       ST_DRAIN = 1'b1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_NEAR = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [0:0] state;

    logic [DEPTH-1:0]  s_occ;
    logic [DEPTH-1:0]  s_gt;
    logic [FREQ_W-1:0] s_freq [DEPTH];
    logic [SYM_W-1:0]  s_sym  [DEPTH];

    logic accept;
    logic pop;

    assign in_ready  = (state == ST_LOAD) && (count < CNT_FULL);
    assign out_valid = (state == ST_DRAIN) && (count != '0);
    assign out_last  = (state == ST_DRAIN) && (count == CNT_ONE);
    assign out_freq  = s_freq[0];
    assign out_sym   = s_sym[0];

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic              p_gt;
        logic              p_occ;
        logic [FREQ_W-1:0] p_freq;
        logic [SYM_W-1:0]  p_sym;
        logic              n_occ;
        logic [FREQ_W-1:0] n_freq;
        logic [SYM_W-1:0]  n_sym;

        if (i == 0) begin : g_bottom
            assign p_gt   = 1'b0;
            assign p_occ  = 1'b0;
            assign p_freq = '1;
            assign p_sym  = '1;
        end else begin : g_lower
            assign p_gt   = s_gt[i-1];
            assign p_occ  = s_occ[i-1];
            assign p_freq = s_freq[i-1];
            assign p_sym  = s_sym[i-1];
        end

        if (i == DEPTH - 1) begin : g_top
            assign n_occ  = 1'b0;
            assign n_freq = '1;
            assign n_sym  = '1;
        end else begin : g_upper
            assign n_occ  = s_occ[i+1];
            assign n_freq = s_freq[i+1];
            assign n_sym  = s_sym[i+1];
        end

        huff_sort_slot #(
            .FREQ_W (FREQ_W),
            .SYM_W  (SYM_W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr),
            .ins       (accept),
            .pop       (pop),
            .new_freq  (in_freq),
            .new_sym   (in_sym),
            .prev_gt   (p_gt),
            .prev_occ  (p_occ),
            .prev_freq (p_freq),
            .prev_sym  (p_sym),
            .next_occ  (n_occ),
            .next_freq (n_freq),
            .next_sym  (n_sym),
            .occ       (s_occ[i]),
            .freq      (s_freq[i]),
            .sym       (s_sym[i]),
            .gt        (s_gt[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_LOAD;
            count <= '0;
        end else if (clr) begin
            state <= ST_LOAD;
            count <= '0;
        end else begin
            if (accept) begin
                count <= count + CNT_ONE;
                // The batch closes on in_last or when this pair fills the last slot.
                if (in_last || (count == CNT_NEAR)) begin
                    state <= ST_DRAIN;
                end
            end else if (pop) begin
                count <= count - CNT_ONE;
                if (out_last) begin
                    state <= ST_LOAD;
                end
            end
        end
    end

endmodule

// File: doc/huff_freq_sorter.md
Name: huff_freq_sorter

Overview:
- Sequential insertion sorter for the Huffman encoder's sort stage.
- Sits directly downstream of the frequency-count registers, which idle at all-ones after a serial load.
- Accepts (frequency, symbol) pairs one per cycle and keeps them in ascending-frequency order in a register array.
- When the batch ends, drains them lowest-first to the tree builder through a valid/ready handshake.

Parameters:
- DEPTH, 16, number of sort slots (maximum symbols per batch), must be ≥2
- FREQ_W, 8, frequency (sort key) width
- SYM_W, 8, symbol width
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

Ports:
- clk  input  1  rising-edge clock; single clock domain
- rst  input  1  asynchronous, active-high reset
- clr  input  1  synchronous clear; empties all slots and returns to LOAD
- in_valid  input  1  input pair valid
- in_ready  output  1  sorter can accept a pair this cycle
- in_freq  input  FREQ_W  frequency key
- in_sym  input  SYM_W  symbol
- in_last  input  1  final pair of the batch
- out_valid  output  1  head pair valid
- out_ready  input  1  downstream accepts head pair
- out_freq  output  FREQ_W  head frequency (lowest)
- out_sym  output  SYM_W  head symbol
- out_last  output  1  head is the final remaining pair
- count  output  CNT_W  number of occupied slots

Behaviour:
- Slot contents: each slot holds {occ, freq, sym}. An empty slot has occ=0 and freq/sym all-ones.
- Ordering: occupied slots always precede empty ones. Comparison uses occ first, so an input freq of all-ones still sorts before empty slots.
- Reset (rst=1, async): all slots empty, state=LOAD, count=0, in_ready=1, out_valid=0, out_last=0, out_freq/out_sym all-ones.
- Priority: rst > clr > normal operation.
- clr in any state: same values as reset, applied on the next edge. A handshake in the same cycle is discarded.
- LOAD state:
  - in_ready = (count < DEPTH); out_valid=0.
  - On in_valid&in_ready, the pair is inserted in a single cycle by a parallel shift-insert.
    - Slot i takes the new pair if it is the first position whose key exceeds the new key (or that is empty).
    - Slots above that position take slot i-1; slots below hold.
  - count increments by 1. The sorted result is visible the cycle after acceptance.
- LOAD → DRAIN: on the cycle after an accepted in_last, or an accept that makes count==DEPTH, whichever comes first. in_ready drops to 0 in DRAIN.
- DRAIN state:
  - out_valid = (count > 0); out_freq/out_sym = slot0; out_last = (count == 1).
  - On out_valid&out_ready, all slots shift down by one, slot DEPTH-1 becomes empty, and count decrements.
  - out_ready low holds the outputs stable.
- DRAIN → LOAD: on the cycle after the pop with out_last=1. in_ready=1 in that next cycle.
- Latency: first out_valid occurs 1 cycle after the last accepted input. Throughput is 1 pair/cycle in each direction.
- Ties (default): a new pair is inserted after existing pairs with an equal key, giving stable arrival order.
- in_valid while not in_ready: the pair is ignored and no state changes.

Optional Feature:
- Macro: SORT_NEW_FIRST_TIE_EN.
- Defined: a new pair is inserted before existing pairs with an equal key, so ties drain newest-first. This matches tree-builder variants that prefer freshly merged nodes.
- Undefined: stable ordering as described in Behaviour.
- Only the tie comparison changes (≤ becomes <). All other behaviour and timing are identical.

Decomposition:
- huff_sort_pkg:
  - default FREQ_W/SYM_W constants
  - slot struct typedef {occ, freq, sym}
  - state enum {LOAD, DRAIN}
  - EMPTY_SLOT constant (occ=0, all-ones)
- Sub-module huff_sort_slot: one slot register with its keep/take-new/take-lower-neighbour/take-upper-neighbour select and key compare. It is instantiated DEPTH times. The top module holds the FSM, count, and handshakes.

Test Plan:
- Reset: assert rst mid-cycle → immediately count=0, out_valid=0, in_ready=1, out_freq=8'hFF.
- Basic sort: insert freq 5,3,9,1 (sym A,B,C,D), last on D → drains (1,D),(3,B),(5,A),(9,C); out_last only on (9,C); then in_ready=1.
- Ties: insert (4,A),(4,B),(2,C),last → drains C,A,B. With SORT_NEW_FIRST_TIE_EN defined → C,B,A.
- Full auto-drain: DEPTH=4, insert 7,6,5,4 with no last → in_ready=0 after the 4th pair; drains 4,5,6,7.
- Key FF: insert (FF,X),(00,Y),last → drains Y then X; X has out_last=1 and is not lost among empty slots.
- Backpressure and clear:
  - out_ready low for 3 cycles in DRAIN → head stable, count unchanged.
  - clr during LOAD with count=3 → count=0 next cycle and the next batch sorts correctly.
